// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM wave generator and its duty sequencer.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UP       = 3'd1,
        ST_HOLD_TOP = 3'd2,
        ST_DOWN     = 3'd3,
        ST_HOLD_BOT = 3'd4
    } state_t;

    localparam logic ON   = 1'b1;
    localparam logic OFF  = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Saturate a requested duty to the period ceiling (100 %).
    function automatic logic [31:0] clamp_duty(input logic [31:0] i_duty,
                                               input logic [31:0] i_ceil);
        return (i_duty > i_ceil) ? i_ceil : i_duty;
    endfunction

endpackage

// File: rtl/pwm_duty_ramp.sv
// Triangle/sawtooth duty sequencer; steps only on PWM period boundaries so
// the generator never sees a mid-period duty change.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int pWIDTH  = 20,
    parameter int pPERIOD = 1000_000,
    parameter int pSTEP   = 10_000,
    parameter int pHOLD   = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic              i_end_tick,
    input  logic              i_load,
    input  logic [pWIDTH-1:0] i_load_duty,
    output logic [pWIDTH-1:0] o_cyc_duty,
    output logic              o_dir,
    output logic              o_top_tick,
    output logic              o_bot_tick
);

    localparam logic [pWIDTH-1:0] lpPER  = pWIDTH'(pPERIOD);
    localparam logic [pWIDTH-1:0] lpSTEP = pWIDTH'(pSTEP);
    localparam logic [15:0]       lpHOLD = 16'(pHOLD);

    state_t            r_state;
    logic [pWIDTH-1:0] r_duty;
    logic              r_dir;
    logic [15:0]       r_hold_cnt;
    logic              r_top;
    logic              r_bot;

    state_t            w_state_nxt;
    logic [pWIDTH-1:0] w_duty_nxt;
    logic              w_dir_nxt;
    logic [15:0]       w_hold_nxt;
    logic              w_top_nxt;
    logic              w_bot_nxt;

    // Step candidates shared by the next-state and output logic. The up sum
    // carries one extra bit so a step past the ceiling cannot wrap.
    logic [pWIDTH:0]   w_up_sum;
    logic              w_up_sat;
    logic [pWIDTH-1:0] w_up_duty;
    logic              w_dn_zero;
    logic [pWIDTH-1:0] w_dn_duty;
    logic              w_hold_done;
    logic [pWIDTH-1:0] w_load_clamped;

    assign w_up_sum       = {1'b0, r_duty} + {1'b0, lpSTEP};
    assign w_up_sat       = (w_up_sum >= {1'b0, lpPER});
    assign w_up_duty      = w_up_sat ? lpPER : w_up_sum[pWIDTH-1:0];
    assign w_dn_zero      = (r_duty <= lpSTEP);
    assign w_dn_duty      = w_dn_zero ? '0 : (r_duty - lpSTEP);
    assign w_hold_done    = (r_hold_cnt == lpHOLD);
    assign w_load_clamped = pWIDTH'(clamp_duty(32'(i_load_duty), 32'(pPERIOD)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_dir      <= HIGH;
            r_hold_cnt <= '0;
            r_top      <= LOW;
            r_bot      <= LOW;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_dir      <= w_dir_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_top      <= w_top_nxt;
            r_bot      <= w_bot_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_load) begin
            if (!i_en)      w_state_nxt = ST_IDLE;
            else if (r_dir) w_state_nxt = ST_UP;
            else            w_state_nxt = ST_DOWN;
        end else if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = r_dir ? ST_UP : ST_DOWN;
                ST_UP:       if (i_end_tick && w_up_sat) w_state_nxt = ST_HOLD_TOP;
                ST_HOLD_TOP: begin
                    if (i_end_tick && w_hold_done) begin
                        if (i_mode)         w_state_nxt = ST_UP;
                        else if (w_dn_zero) w_state_nxt = ST_HOLD_BOT;
                        else                w_state_nxt = ST_DOWN;
                    end
                end
                ST_DOWN:     if (i_end_tick && w_dn_zero) w_state_nxt = ST_HOLD_BOT;
                ST_HOLD_BOT: begin
                    if (i_end_tick && w_hold_done)
                        w_state_nxt = w_up_sat ? ST_HOLD_TOP : ST_UP;
                end
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir;
        w_hold_nxt = r_hold_cnt;
        w_top_nxt  = LOW;
        w_bot_nxt  = LOW;
        if (i_load) begin
            // A forced value never raises a tick, even at 0 or the ceiling.
            w_duty_nxt = w_load_clamped;
            w_hold_nxt = '0;
        end else if (!i_en) begin
            w_hold_nxt = '0;
        end else if (i_end_tick) begin
            case (r_state)
                ST_UP: begin
                    w_duty_nxt = w_up_duty;
                    w_top_nxt  = w_up_sat;
                end
                ST_HOLD_TOP: begin
                    if (w_hold_done) begin
                        w_hold_nxt = '0;
                        if (i_mode) begin
                            w_duty_nxt = '0;
                            w_bot_nxt  = HIGH;
                        end else begin
                            w_dir_nxt  = LOW;
                            w_duty_nxt = w_dn_duty;
                            w_bot_nxt  = w_dn_zero;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + 16'd1;
                    end
                end
                ST_DOWN: begin
                    w_duty_nxt = w_dn_duty;
                    w_bot_nxt  = w_dn_zero;
                end
                ST_HOLD_BOT: begin
                    if (w_hold_done) begin
                        w_hold_nxt = '0;
                        w_dir_nxt  = HIGH;
                        w_duty_nxt = w_up_duty;
                        w_top_nxt  = w_up_sat;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cyc_duty = r_duty;
    assign o_dir      = r_dir;
    assign o_top_tick = r_top;
    assign o_bot_tick = r_bot;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench: expectations queued with each strobe, popped the cycle after.
module tb_pwm_duty_ramp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         end_tick = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_duty = '0;

    logic [W-1:0] duty0, duty2;
    logic         dir0, dir2, top0, top2, bot0, bot2;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.pWIDTH(W), .pPERIOD(100), .pSTEP(30), .pHOLD(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_end_tick(end_tick),
        .i_load(load), .i_load_duty(load_duty),
        .o_cyc_duty(duty0), .o_dir(dir0), .o_top_tick(top0), .o_bot_tick(bot0));

    pwm_duty_ramp #(.pWIDTH(W), .pPERIOD(100), .pSTEP(30), .pHOLD(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_end_tick(end_tick),
        .i_load(load), .i_load_duty(load_duty),
        .o_cyc_duty(duty2), .o_dir(dir2), .o_top_tick(top2), .o_bot_tick(bot2));

    typedef struct {
        logic         sel;
        int           id;
        logic [W-1:0] duty;
        logic         dir;
        logic         top;
        logic         bot;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_exp = 0;
    logic chk_req = 1'b0;
    logic due = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic s, input logic [W-1:0] d, input logic dr,
                        input logic tp, input logic bt);
        exp_t e;
        n_exp++;
        e.sel = s; e.id = n_exp; e.duty = d; e.dir = dr; e.top = tp; e.bot = bt;
        q.push_back(e);
    endtask

    always @(posedge clk) due <= chk_req;

    always @(negedge clk) begin
        if (due) begin
            if (q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("duty#%0d", e.id), e.sel ? duty2 : duty0, e.duty);
                chk($sformatf("dir#%0d",  e.id), e.sel ? dir2  : dir0,  e.dir);
                chk($sformatf("top#%0d",  e.id), e.sel ? top2  : top0,  e.top);
                chk($sformatf("bot#%0d",  e.id), e.sel ? bot2  : bot0,  e.bot);
            end
        end
    end

    // One clock of stimulus; when c is set the expected post-edge outputs are queued.
    task automatic cyc(input logic t, input logic ld, input logic [W-1:0] ldv,
                       input logic c, input logic s, input logic [W-1:0] d,
                       input logic dr, input logic tp, input logic bt);
        @(negedge clk);
        end_tick  = t;
        load      = ld;
        load_duty = ldv;
        chk_req   = c;
        if (c) push(s, d, dr, tp, bt);
    endtask

    task automatic idle4();
        repeat (4) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic period(input logic s, input logic [W-1:0] d, input logic dr,
                          input logic tp, input logic bt);
        idle4();
        cyc(1'b1, 1'b0, '0, 1'b1, s, d, dr, tp, bt);
    endtask

    task automatic do_reset(input logic s, input logic md);
        @(negedge clk);
        rst = 1'b1; mode = md; end_tick = 1'b0; load = 1'b0; chk_req = 1'b1;
        push(s, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; chk_req = 1'b0; en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Triangle, no dwell
        do_reset(1'b0, 1'b0);
        period(0, 30, 1, 0, 0);  period(0, 60, 1, 0, 0);  period(0, 90, 1, 0, 0);
        period(0, 100, 1, 1, 0); period(0, 70, 0, 0, 0);  period(0, 40, 0, 0, 0);
        period(0, 10, 0, 0, 0);  period(0, 0, 0, 0, 1);   period(0, 30, 1, 0, 0);

        // Triangle, two-period dwell at the top
        do_reset(1'b1, 1'b0);
        period(1, 30, 1, 0, 0);  period(1, 60, 1, 0, 0);  period(1, 90, 1, 0, 0);
        period(1, 100, 1, 1, 0); period(1, 100, 1, 0, 0); period(1, 100, 1, 0, 0);
        period(1, 70, 0, 0, 0);

        // Sawtooth
        do_reset(1'b0, 1'b1);
        period(0, 30, 1, 0, 0);  period(0, 60, 1, 0, 0);  period(0, 90, 1, 0, 0);
        period(0, 100, 1, 1, 0); period(0, 0, 1, 0, 1);   period(0, 30, 1, 0, 0);

        // Load coinciding with end_tick while ramping down: clamped, no tick
        do_reset(1'b0, 1'b0);
        period(0, 30, 1, 0, 0);  period(0, 60, 1, 0, 0);  period(0, 90, 1, 0, 0);
        period(0, 100, 1, 1, 0); period(0, 70, 0, 0, 0);
        idle4();
        cyc(1'b1, 1'b1, 8'd200, 1'b1, 1'b0, 100, 0, 0, 0);
        period(0, 70, 0, 0, 0);  period(0, 40, 0, 0, 0);

        // Enable dropped mid-ramp: end_ticks ignored, resumes from 60
        do_reset(1'b0, 1'b0);
        period(0, 30, 1, 0, 0);  period(0, 60, 1, 0, 0);
        @(negedge clk);
        en = 1'b0; end_tick = 1'b0; chk_req = 1'b0;
        period(0, 60, 1, 0, 0);  period(0, 60, 1, 0, 0);  period(0, 60, 1, 0, 0);
        @(negedge clk);
        en = 1'b1; end_tick = 1'b0; chk_req = 1'b0;
        period(0, 90, 1, 0, 0);

        // Reset while dwelling at the top discards the profile
        do_reset(1'b1, 1'b0);
        period(1, 30, 1, 0, 0);  period(1, 60, 1, 0, 0);  period(1, 90, 1, 0, 0);
        period(1, 100, 1, 1, 0); period(1, 100, 1, 0, 0);
        do_reset(1'b1, 1'b0);
        period(1, 30, 1, 0, 0);

        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sb_drain", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
